soin_bpredictor_trainer: RTL and testbench

//  Execute-side partner of the fetch bimodal predictor. Resolves each branch from execute

---
 rtl/soin_bpredictor_trainer.sv | 123 ++++++++++++
 tb/tb_soin_bpredictor_trainer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soin_bpredictor_trainer.sv
// Execute-side branch resolver for the bimodal predictor: computes counter updates,
// queues them toward the predictor table write port, and raises a registered fetch redirect.
module soin_bpredictor_trainer #(
   parameter int IDX_W  = 12,
   parameter int META_W = 14,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic              ex_train,
   input  logic [31:0]       ex_PC,
   input  logic              ex_actual_dir,
   input  logic [31:0]       ex_actual_target,
   input  logic              ex_pred_dir,
   input  logic [31:0]       ex_pred_target,
   input  logic [META_W-1:0] ex_meta,
   output logic              ex_stall,
   output logic              execute_bpredictor_update,
   output logic [31:0]       execute_bpredictor_PC,
   output logic [31:0]       execute_bpredictor_target,
   output logic              execute_bpredictor_dir,
   output logic              execute_bpredictor_miss,
   output logic [META_W-1:0] execute_bpredictor_meta,
   input  logic              bpredictor_upd_ready,
   output logic              fetch_redirect,
   output logic [31:0]       fetch_redirect_PC
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int CTR_W = META_W - IDX_W;

   logic [31:0]       q_pc     [DEPTH];
   logic [31:0]       q_target [DEPTH];
   logic              q_dir    [DEPTH];
   logic              q_miss   [DEPTH];
   logic [META_W-1:0] q_meta   [DEPTH];

   logic [PTR_W-1:0] wr_ptr, rd_ptr, scan_ptr;
   logic [CNT_W-1:0] count;

   logic              accept, enq, deq, miss;
   logic [31:0]       next_pc;
   logic [CTR_W-1:0]  base_ctr, new_ctr;
   logic [IDX_W-1:0]  ex_idx;

   assign ex_idx   = ex_meta[IDX_W-1:0];
   assign ex_stall = (count == CNT_W'(DEPTH));
   assign accept   = ex_valid & ~ex_stall;
   assign next_pc  = ex_actual_dir ? ex_actual_target : ex_PC + 32'd4;
   assign miss     = (ex_pred_dir != ex_actual_dir) | (ex_pred_target != next_pc);
   assign enq      = accept & (ex_train | miss);
   assign deq      = execute_bpredictor_update & bpredictor_upd_ready;

   // Scan oldest to youngest so the youngest matching queued entry wins;
   // the head is still scanned even when it dequeues this cycle.
   always_comb begin
      base_ctr = ex_meta[META_W-1:IDX_W];
      scan_ptr = rd_ptr;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         scan_ptr = rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < count) && (q_meta[scan_ptr][IDX_W-1:0] == ex_idx))
            base_ctr = q_meta[scan_ptr][META_W-1:IDX_W];
      end
   end

   always_comb begin
      new_ctr = base_ctr;
      if (ex_train) begin
         if (ex_actual_dir) begin
            if (base_ctr != '1) new_ctr = base_ctr + CTR_W'(1);
         end else begin
            if (base_ctr != '0) new_ctr = base_ctr - CTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_pc[i]     <= '0;
            q_target[i] <= '0;
            q_dir[i]    <= 1'b0;
            q_miss[i]   <= 1'b0;
            q_meta[i]   <= '0;
         end
      end else begin
         if (enq) begin
            q_pc[wr_ptr]     <= ex_PC;
            q_target[wr_ptr] <= ex_actual_target;
            q_dir[wr_ptr]    <= ex_actual_dir;
            q_miss[wr_ptr]   <= miss;
            q_meta[wr_ptr]   <= {new_ctr, ex_idx};
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         if (enq && !deq)      count <= count + CNT_W'(1);
         else if (!enq && deq) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_redirect    <= 1'b0;
         fetch_redirect_PC <= '0;
      end else begin
         fetch_redirect <= accept & miss;
         if (accept && miss) fetch_redirect_PC <= next_pc;
      end
   end

   assign execute_bpredictor_update = (count != '0);
   assign execute_bpredictor_PC     = q_pc[rd_ptr];
   assign execute_bpredictor_target = q_target[rd_ptr];
   assign execute_bpredictor_dir    = q_dir[rd_ptr];
   assign execute_bpredictor_miss   = q_miss[rd_ptr];
   assign execute_bpredictor_meta   = q_meta[rd_ptr];

endmodule

// File: tb/tb_soin_bpredictor_trainer.sv
// Scoreboard bench for soin_bpredictor_trainer: expected table updates are queued at
// issue and compared as the predictor accepts them; redirects are checked inline.
module tb_soin_bpredictor_trainer;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        dir;
      logic        miss;
      logic [13:0] meta;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ex_valid = 1'b0, ex_train = 1'b0, ex_actual_dir = 1'b0, ex_pred_dir = 1'b0;
   logic [31:0] ex_PC = '0, ex_actual_target = '0, ex_pred_target = '0;
   logic [13:0] ex_meta = '0;
   logic        ex_stall, upd, upd_dir, upd_miss, bpredictor_upd_ready = 1'b0;
   logic [31:0] upd_pc, upd_target, fetch_redirect_PC;
   logic [13:0] upd_meta;
   logic        fetch_redirect;

   int     checks = 0;
   int     errors = 0;
   entry_t exp_q[$];

   soin_bpredictor_trainer #(.IDX_W(12), .META_W(14), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_train(ex_train), .ex_PC(ex_PC),
      .ex_actual_dir(ex_actual_dir), .ex_actual_target(ex_actual_target),
      .ex_pred_dir(ex_pred_dir), .ex_pred_target(ex_pred_target), .ex_meta(ex_meta),
      .ex_stall(ex_stall), .execute_bpredictor_update(upd), .execute_bpredictor_PC(upd_pc),
      .execute_bpredictor_target(upd_target), .execute_bpredictor_dir(upd_dir),
      .execute_bpredictor_miss(upd_miss), .execute_bpredictor_meta(upd_meta),
      .bpredictor_upd_ready(bpredictor_upd_ready), .fetch_redirect(fetch_redirect),
      .fetch_redirect_PC(fetch_redirect_PC)
   );

   always #5 clk = ~clk;

   // Drain monitor: every accepted head must match the oldest expected update.
   always @(negedge clk) begin
      if (!reset && upd && bpredictor_upd_ready) begin
         entry_t got, want;
         got = {upd_pc, upd_target, upd_dir, upd_miss, upd_meta};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL drain_unexpected got pc=%h meta=%h required none", upd_pc, upd_meta);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               errors++;
               $display("FAIL drain_entry got pc=%h tgt=%h dir=%b miss=%b meta=%h required pc=%h tgt=%h dir=%b miss=%b meta=%h",
                        got.pc, got.target, got.dir, got.miss, got.meta,
                        want.pc, want.target, want.dir, want.miss, want.meta);
            end
         end
      end
   end

   // Called at #1 after a posedge; returns at #1 after the accepting edge.
   task automatic send(input logic train, input logic [31:0] pc, input logic adir,
                       input logic [31:0] atgt, input logic pdir, input logic [31:0] ptgt,
                       input logic [13:0] meta, input logic [1:0] exp_ctr, output int waited);
      logic [31:0] nxt;
      logic        m;
      ex_valid = 1'b1; ex_train = train; ex_PC = pc; ex_actual_dir = adir;
      ex_actual_target = atgt; ex_pred_dir = pdir; ex_pred_target = ptgt; ex_meta = meta;
      waited = 0;
      while (ex_stall && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      if (ex_stall) begin
         checks++; errors++;
         $display("FAIL send_stall_timeout got stall=1 required 0 within 40 cycles");
      end
      nxt = adir ? atgt : pc + 32'd4;
      m   = (pdir != adir) || (ptgt != nxt);
      if (train || m) exp_q.push_back({pc, atgt, adir, m, {exp_ctr, meta[11:0]}});
      @(posedge clk); #1;
   endtask

   task automatic idle();
      ex_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_empty();
      int n = 0;
      ex_valid = 1'b0;
      bpredictor_upd_ready = 1'b1;
      while (upd && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (upd !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_empty got update=%b pending=%0d required update=0 pending=0", upd, exp_q.size());
      end
   endtask

   task automatic test_reset();
      int w;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({upd, ex_stall, fetch_redirect, fetch_redirect_PC, upd_meta, upd_pc} !== '0) begin
         errors++;
         $display("FAIL reset_init got upd=%b stall=%b redir=%b rpc=%h meta=%h pc=%h required all 0",
                  upd, ex_stall, fetch_redirect, fetch_redirect_PC, upd_meta, upd_pc);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      bpredictor_upd_ready = 1'b0;
      send(1, 32'h80, 1, 32'h90, 1, 32'h90, {2'b01, 12'h001}, 2'b10, w);
      send(1, 32'h84, 1, 32'hA0, 1, 32'hA0, {2'b01, 12'h002}, 2'b10, w);
      send(1, 32'h88, 1, 32'hB0, 0, 32'h8C, {2'b01, 12'h003}, 2'b10, w);
      checks++;
      if (fetch_redirect !== 1'b1 || upd !== 1'b1) begin
         errors++;
         $display("FAIL reset_prestate got redir=%b upd=%b required 1 1", fetch_redirect, upd);
      end
      ex_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (upd !== 1'b0 || fetch_redirect !== 1'b0 || ex_stall !== 1'b0 || fetch_redirect_PC !== 32'h0) begin
         errors++;
         $display("FAIL reset_midstream got upd=%b redir=%b stall=%b rpc=%h required 0 0 0 0",
                  upd, fetch_redirect, ex_stall, fetch_redirect_PC);
      end
      exp_q.delete();
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int w;
      bpredictor_upd_ready = 1'b1;
      send(1, 32'h100, 1, 32'h1000, 0, 32'h104, {2'b01, 12'h0A5}, 2'b10, w);
      checks++;
      if (fetch_redirect !== 1'b1 || fetch_redirect_PC !== 32'h1000) begin
         errors++;
         $display("FAIL basic_redirect got redir=%b rpc=%h required 1 00001000", fetch_redirect, fetch_redirect_PC);
      end
      checks++;
      if (upd !== 1'b1 || upd_meta !== 14'h20A5 || upd_miss !== 1'b1) begin
         errors++;
         $display("FAIL basic_head got upd=%b meta=%h miss=%b required 1 20a5 1", upd, upd_meta, upd_miss);
      end
      idle();
      checks++;
      if (fetch_redirect !== 1'b0 || fetch_redirect_PC !== 32'h1000) begin
         errors++;
         $display("FAIL basic_redirect_drop got redir=%b rpc=%h required 0 00001000", fetch_redirect, fetch_redirect_PC);
      end
      wait_empty();
   endtask

   task automatic test_saturation();
      int w;
      bpredictor_upd_ready = 1'b1;
      send(1, 32'h200, 1, 32'h300, 1, 32'h300, {2'b11, 12'h011}, 2'b11, w);
      send(1, 32'h204, 0, 32'h300, 0, 32'h208, {2'b00, 12'h012}, 2'b00, w);
      send(1, 32'h208, 0, 32'h300, 0, 32'h20C, {2'b10, 12'h013}, 2'b01, w);
      checks++;
      if (fetch_redirect !== 1'b0) begin
         errors++;
         $display("FAIL sat_no_redirect got redir=%b required 0", fetch_redirect);
      end
      wait_empty();
   endtask

   task automatic test_forward();
      int w;
      bpredictor_upd_ready = 1'b0;
      send(1, 32'h400, 1, 32'h480, 1, 32'h480, {2'b00, 12'h03C}, 2'b01, w);
      send(1, 32'h404, 1, 32'h480, 1, 32'h480, {2'b00, 12'h03C}, 2'b10, w);
      checks++;
      if (upd_meta !== 14'h103C || upd_pc !== 32'h400) begin
         errors++;
         $display("FAIL fwd_head got meta=%h pc=%h required 103c 00000400", upd_meta, upd_pc);
      end
      wait_empty();
      // Older matching entry dequeues on the same edge the younger one enqueues.
      bpredictor_upd_ready = 1'b1;
      send(1, 32'h500, 1, 32'h580, 1, 32'h580, {2'b01, 12'h055}, 2'b10, w);
      send(1, 32'h504, 1, 32'h580, 1, 32'h580, {2'b01, 12'h055}, 2'b11, w);
      wait_empty();
   endtask

   task automatic test_full();
      int w;
      bpredictor_upd_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(1, 32'h600 + 32'(i * 4), 1, 32'h700, 1, 32'h700, {2'b01, 12'h100 + 12'(i)}, 2'b10, w);
      checks++;
      if (ex_stall !== 1'b1) begin
         errors++;
         $display("FAIL full_stall got stall=%b required 1", ex_stall);
      end
      fork
         send(1, 32'h610, 1, 32'h700, 1, 32'h700, {2'b01, 12'h104}, 2'b10, w);
         begin
            repeat (2) @(posedge clk);
            #1 bpredictor_upd_ready = 1'b1;
         end
      join
      checks++;
      if (w != 3) begin
         errors++;
         $display("FAIL full_release got wait=%0d required 3", w);
      end
      wait_empty();
   endtask

   task automatic test_back_to_back();
      int w;
      bpredictor_upd_ready = 1'b1;
      send(0, 32'h800, 1, 32'h900, 1, 32'h900, {2'b10, 12'h077}, 2'b10, w);
      checks++;
      if (fetch_redirect !== 1'b0 || upd !== 1'b0) begin
         errors++;
         $display("FAIL notrain_drop got redir=%b upd=%b required 0 0", fetch_redirect, upd);
      end
      send(1, 32'hFFFFFFFC, 0, 32'h2000, 1, 32'h2000, {2'b10, 12'h078}, 2'b01, w);
      checks++;
      if (fetch_redirect !== 1'b1 || fetch_redirect_PC !== 32'h0) begin
         errors++;
         $display("FAIL call_wrap got redir=%b rpc=%h required 1 00000000", fetch_redirect, fetch_redirect_PC);
      end
      send(0, 32'h700, 1, 32'h800, 0, 32'h704, {2'b11, 12'h079}, 2'b11, w);
      checks++;
      if (fetch_redirect !== 1'b1 || fetch_redirect_PC !== 32'h800) begin
         errors++;
         $display("FAIL b2b_first got redir=%b rpc=%h required 1 00000800", fetch_redirect, fetch_redirect_PC);
      end
      send(0, 32'h710, 0, 32'h900, 1, 32'h900, {2'b00, 12'h07A}, 2'b00, w);
      checks++;
      if (fetch_redirect !== 1'b1 || fetch_redirect_PC !== 32'h714) begin
         errors++;
         $display("FAIL b2b_second got redir=%b rpc=%h required 1 00000714", fetch_redirect, fetch_redirect_PC);
      end
      idle();
      checks++;
      if (fetch_redirect !== 1'b0 || fetch_redirect_PC !== 32'h714) begin
         errors++;
         $display("FAIL b2b_hold got redir=%b rpc=%h required 0 00000714", fetch_redirect, fetch_redirect_PC);
      end
      wait_empty();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_forward();
      test_full();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
